// File: rtl/cp_route_pkg.sv
// Control-plane routing crossbar: shared constants, entry type, address decode.
package cp_route_pkg;

  localparam int CP_ADDR_W = 37;
  localparam int CP_DATA_W = 28;
  localparam int CP_ID_W   = 4;

  typedef struct packed {
    logic       drop;
    logic [7:0] sel;
  } cp_dec_t;

  typedef struct packed {
    logic [CP_ADDR_W-1:0] addr;
    logic [CP_DATA_W-1:0] data;
    logic [CP_ID_W-1:0]   src_id;
  } cp_entry_t;

  // Out-of-range selects and non-secure->secure accesses are dropped.
  function automatic cp_dec_t cp_decode(
    input logic [127:0] addr,
    input int           sel_lsb,
    input int           sel_w,
    input int           n_dst,
    input logic [31:0]  dst_sec,
    input logic         src_sec
  );
    cp_dec_t r;
    r.sel  = 8'(addr >> sel_lsb) & 8'((32'd1 << sel_w) - 32'd1);
    if (int'({24'd0, r.sel}) >= n_dst)
      r.drop = 1'b1;
    else
      r.drop = dst_sec[r.sel[4:0]] & ~src_sec;
    return r;
  endfunction

endpackage

// File: rtl/cp_route_fifo.sv
// Per-destination synchronous FIFO; head output forced to zero when empty.
module cp_route_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & (r_cnt != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + AW'(1);
      if (w_do_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= i_din;
  end

  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = o_empty ? '0 : r_mem[r_rp];

endmodule

// File: rtl/cp_route_xbar.sv
// Control-plane crossbar: round-robin arbiter, secure decode, per-dest FIFOs.
module cp_route_xbar
  import cp_route_pkg::*;
#(
  parameter int N_SRC      = 2,
  parameter int N_DST      = 4,
  parameter int ADDR_W     = CP_ADDR_W,
  parameter int DATA_W     = CP_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int SEL_LSB    = 32,
  parameter logic [N_DST-1:0] DST_SECURE = 'b0001,
  parameter logic [N_SRC-1:0] SRC_SECURE = 'b01
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          src_valid,
  output logic [N_SRC-1:0]          src_ready,
  input  logic [N_SRC*ADDR_W-1:0]   src_addr,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_DST-1:0]          dst_valid,
  input  logic [N_DST-1:0]          dst_ready,
  output logic [N_DST*ADDR_W-1:0]   dst_addr,
  output logic [N_DST*DATA_W-1:0]   dst_data,
  output logic [N_DST*((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] dst_src_id,
  output logic                      drop_pulse,
  output logic [15:0]               drop_cnt
);

  localparam int SEL_W = $clog2(N_DST);
  localparam int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W + ID_W;

  cp_dec_t           w_dec;
  logic [N_SRC-1:0]  w_drop;
  logic [N_SRC-1:0]  w_blk;
  logic [N_SRC-1:0]  w_elig;
  logic [7:0]        w_sel [N_SRC];
  logic [N_SRC-1:0]  w_rot;
  logic              w_any;
  logic [ID_W-1:0]   w_win;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic              w_win_drop;
  logic [7:0]        w_win_sel;
  logic [ENT_W-1:0]  w_entry;
  logic [N_DST-1:0]  w_push;
  logic [N_DST-1:0]  w_empty;
  logic [CNT_W-1:0]  w_cnt  [N_DST];
  logic [ENT_W-1:0]  w_head [N_DST];

  logic [ID_W-1:0]   r_rr;
  logic              r_drop_pulse;
  logic [15:0]       r_drop_cnt;

  // Eligibility uses registered counts only: a pop never frees a slot early.
  always_comb begin
    w_dec  = '0;
    w_drop = '0;
    w_blk  = '0;
    w_elig = '0;
    for (int s = 0; s < N_SRC; s++) begin
      w_dec = cp_decode(128'(src_addr[s*ADDR_W +: ADDR_W]), SEL_LSB,
                        SEL_W, N_DST, 32'(DST_SECURE), SRC_SECURE[s]);
      w_sel[s]  = w_dec.sel;
      w_drop[s] = w_dec.drop;
      for (int d = 0; d < N_DST; d++) begin
        if (w_dec.sel == 8'(d) && w_cnt[d] >= CNT_W'(FIFO_DEPTH))
          w_blk[s] = 1'b1;
      end
      w_elig[s] = src_valid[s] & rst & (w_dec.drop | ~w_blk[s]);
    end
  end

  always_comb begin
    w_rot = N_SRC'({w_elig, w_elig} >> r_rr);
    w_any = 1'b0;
    w_win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_any = 1'b1;
        w_win = ID_W'((int'(r_rr) + i) % N_SRC);
      end
    end
  end

  assign src_ready  = w_any ? (N_SRC'(1) << w_win) : '0;
  assign w_win_addr = src_addr[w_win*ADDR_W +: ADDR_W];
  assign w_win_data = src_data[w_win*DATA_W +: DATA_W];
  assign w_win_drop = w_drop[w_win];
  assign w_win_sel  = w_sel[w_win];
  assign w_entry    = {w_win_addr, w_win_data, w_win};

  always_comb begin
    w_push = '0;
    for (int d = 0; d < N_DST; d++)
      w_push[d] = w_any & ~w_win_drop & (w_win_sel == 8'(d));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr         <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_any) r_rr <= ID_W'((int'(w_win) + 1) % N_SRC);
      r_drop_pulse <= w_any & w_win_drop;
      if (w_any && w_win_drop && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

  for (genvar d = 0; d < N_DST; d++) begin : g_dst
    cp_route_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_push[d]),
      .i_din   (w_entry),
      .i_pop   (dst_ready[d]),
      .o_dout  (w_head[d]),
      .o_empty (w_empty[d]),
      .o_count (w_cnt[d])
    );

    assign dst_valid[d] = ~w_empty[d];
    assign dst_addr[d*ADDR_W +: ADDR_W] = w_head[d][ENT_W-1 -: ADDR_W];
    assign dst_data[d*DATA_W +: DATA_W] = w_head[d][ID_W +: DATA_W];
    assign dst_src_id[d*ID_W +: ID_W]   = w_head[d][ID_W-1:0];
  end

endmodule

// File: tb/tb_cp_route_xbar.sv
// Directed bench for cp_route_xbar: routing, arbitration, security, backpressure.
module tb_cp_route_xbar;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   src_valid;
  logic [1:0]   src_ready;
  logic [73:0]  src_addr;
  logic [55:0]  src_data;
  logic [3:0]   dst_valid;
  logic [3:0]   dst_ready;
  logic [147:0] dst_addr;
  logic [111:0] dst_data;
  logic [3:0]   dst_src_id;
  logic         drop_pulse;
  logic [15:0]  drop_cnt;

  logic [1:0]   b_src_valid;
  logic [1:0]   b_src_ready;
  logic [73:0]  b_src_addr;
  logic [55:0]  b_src_data;
  logic [2:0]   b_dst_valid;
  logic [2:0]   b_dst_ready;
  logic [110:0] b_dst_addr;
  logic [83:0]  b_dst_data;
  logic [2:0]   b_dst_src_id;
  logic         b_drop_pulse;
  logic [15:0]  b_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [36:0] A0 = 37'h0_0000_0100;
  localparam logic [36:0] A1 = 37'h1_0000_0040;
  localparam logic [36:0] A2 = 37'h2_0000_0000;
  localparam logic [36:0] A3 = 37'h3_0000_0000;

  cp_route_xbar u_dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data),
    .dst_src_id (dst_src_id),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  cp_route_xbar #(
    .N_DST      (3),
    .DST_SECURE (3'b001)
  ) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (b_src_valid),
    .src_ready  (b_src_ready),
    .src_addr   (b_src_addr),
    .src_data   (b_src_data),
    .dst_valid  (b_dst_valid),
    .dst_ready  (b_dst_ready),
    .dst_addr   (b_dst_addr),
    .dst_data   (b_dst_data),
    .dst_src_id (b_dst_src_id),
    .drop_pulse (b_drop_pulse),
    .drop_cnt   (b_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input int s, input logic [36:0] a,
                     input logic [27:0] d);
    src_addr[s*37 +: 37] = a;
    src_data[s*28 +: 28] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    src_valid   = '0;
    src_addr    = '0;
    src_data    = '0;
    dst_ready   = '0;
    b_src_valid = '0;
    b_src_addr  = '0;
    b_src_data  = '0;
    b_dst_ready = '0;

    // reset state, with a request pending
    repeat (2) @(negedge clk);
    put(0, A1, 28'h1234567);
    src_valid = 2'b01;
    #1;
    chk("rst_ready", 64'(src_ready), 64'h0);
    chk("rst_dvalid", 64'(dst_valid), 64'h0);
    chk("rst_daddr", 64'(dst_addr[37 +: 37]), 64'h0);
    chk("rst_dpulse", 64'(drop_pulse), 64'h0);
    chk("rst_dcnt", 64'(drop_cnt), 64'h0);
    src_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // single route to dst 1
    @(negedge clk);
    put(0, A1, 28'hABCDEF0);
    src_valid = 2'b01;
    dst_ready = 4'b0010;
    #1 chk("t1_ready", 64'(src_ready), 64'h1);
    @(negedge clk);
    src_valid = '0;
    #1;
    chk("t1_dvalid", 64'(dst_valid), 64'h2);
    chk("t1_addr", 64'(dst_addr[37 +: 37]), 64'(A1));
    chk("t1_data", 64'(dst_data[28 +: 28]), 64'hABCDEF0);
    chk("t1_id", 64'(dst_src_id[1]), 64'h0);
    @(negedge clk);
    #1 chk("t1_popped", 64'(dst_valid), 64'h0);

    // round robin toward dst 2
    do_reset();
    put(0, A2, 28'h1111111);
    put(1, A2, 28'h2222222);
    src_valid = 2'b11;
    dst_ready = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), 64'(src_ready),
          (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0)
        chk($sformatf("rr_id%0d", k), 64'(dst_src_id[2]),
            64'((k - 1) % 2));
      @(negedge clk);
    end
    src_valid = '0;

    // secure drop from src1, same access routes from src0
    do_reset();
    dst_ready = 4'b1111;
    put(1, A0, 28'h5A5A5A5);
    src_valid = 2'b10;
    #1 chk("sec_ready1", 64'(src_ready), 64'h2);
    @(negedge clk);
    src_valid = '0;
    #1;
    chk("sec_pulse", 64'(drop_pulse), 64'h1);
    chk("sec_cnt", 64'(drop_cnt), 64'h1);
    chk("sec_noval", 64'(dst_valid), 64'h0);
    @(negedge clk);
    #1;
    chk("sec_pulse_end", 64'(drop_pulse), 64'h0);
    chk("sec_cnt_hold", 64'(drop_cnt), 64'h1);
    put(0, A0, 28'h5A5A5A5);
    src_valid = 2'b01;
    #1 chk("sec_ready0", 64'(src_ready), 64'h1);
    @(negedge clk);
    src_valid = '0;
    #1;
    chk("sec_route", 64'(dst_valid), 64'h1);
    chk("sec_id", 64'(dst_src_id[0]), 64'h0);
    chk("sec_nopulse", 64'(drop_pulse), 64'h0);

    // backpressure on dst 3, src1 skips past the blocked src0
    do_reset();
    dst_ready = 4'b0000;
    src_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      put(0, A3, 28'(k + 16));
      #1 chk($sformatf("bp_fill%0d", k), 64'(src_ready), 64'h1);
      @(negedge clk);
    end
    put(0, A3, 28'h55);
    put(1, A2, 28'h66);
    src_valid = 2'b11;
    #1;
    chk("bp_full", 64'(src_ready), 64'h2);
    chk("bp_dvalid", 64'(dst_valid), 64'h8);
    @(negedge clk);
    #1 chk("bp_skip", 64'(src_ready), 64'h2);
    @(negedge clk);
    src_valid = 2'b01;
    dst_ready = 4'b1000;
    #1 chk("bp_same", 64'(src_ready), 64'h0);
    @(negedge clk);
    dst_ready = 4'b0000;
    #1;
    chk("bp_next", 64'(src_ready), 64'h1);
    chk("bp_head", 64'(dst_data[84 +: 28]), 64'h11);
    @(negedge clk);
    src_valid = '0;

    // reset with two entries waiting in dst 1
    do_reset();
    dst_ready = '0;
    put(0, A1, 28'h0000AAA);
    src_valid = 2'b01;
    @(negedge clk);
    put(0, A1, 28'h0000BBB);
    @(negedge clk);
    src_valid = '0;
    #1 chk("mr_before", 64'(dst_valid), 64'h2);
    #2 rst = 1'b0;
    #1;
    chk("mr_valid", 64'(dst_valid), 64'h0);
    chk("mr_addr", 64'(dst_addr[37 +: 37]), 64'h0);
    chk("mr_data", 64'(dst_data[28 +: 28]), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("mr_after", 64'(dst_valid), 64'h0);

    // N_DST=3: sel=3 is out of range, counter saturates
    @(negedge clk);
    b_src_addr[36:0] = A3;
    b_src_valid      = 2'b01;
    #1 chk("oor_ready", 64'(b_src_ready), 64'h1);
    @(negedge clk);
    #1;
    chk("oor_pulse", 64'(b_drop_pulse), 64'h1);
    chk("oor_cnt1", 64'(b_drop_cnt), 64'h1);
    chk("oor_noval", 64'(b_dst_valid), 64'h0);
    repeat (65539) @(posedge clk);
    @(negedge clk);
    b_src_valid = '0;
    #1;
    chk("sat_cnt", 64'(b_drop_cnt), 64'hFFFF);
    chk("sat_pulse", 64'(b_drop_pulse), 64'h1);
    @(negedge clk);
    #1;
    chk("sat_hold", 64'(b_drop_cnt), 64'hFFFF);
    chk("sat_pulse_end", 64'(b_drop_pulse), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
